// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state, mode and width definitions for the Fibonacci generator
package fib_pkg;

  localparam int FIB_N_W    = 8;
  localparam int FIB_DATA_W = 32;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    EMIT   = 2'd2,
    STREAM = 2'd3
  } fib_state_t;

endpackage

// File: rtl/fib_gen_if.sv
// rtl/fib_gen_if.sv - request/result handshake bundle for the Fibonacci generator
interface fib_gen_if
  import fib_pkg::*;
#(
  parameter int N_W    = FIB_N_W,
  parameter int DATA_W = FIB_DATA_W
);

  logic [N_W-1:0]    fib_in;
  logic              mode_in;
  logic              vld_in;
  logic              rdy_in;
  logic [DATA_W-1:0] fib_out;
  logic              ovf_out;
  logic              last_out;
  logic              vld_out;
  logic              rdy_out;
  logic              busy;

  modport master (
    output fib_in, mode_in, vld_in, rdy_out,
    input  rdy_in, fib_out, ovf_out, last_out, vld_out, busy
  );

  modport slave (
    input  fib_in, mode_in, vld_in, rdy_out,
    output rdy_in, fib_out, ovf_out, last_out, vld_out, busy
  );

endinterface

// File: rtl/fib_step.sv
// rtl/fib_step.sv - one combinational Fibonacci advance with overflow tracking
module fib_step
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              ovf_a,
  input  logic              ovf_b,
  output logic [DATA_W-1:0] a_nxt,
  output logic [DATA_W-1:0] b_nxt,
  output logic              ovf_a_nxt,
  output logic              ovf_b_nxt
);

  logic carry;

  // shift the pair down and add; a carry or an already-wrapped term marks the new term as wrapped
  always_comb begin
    {carry, b_nxt} = {1'b0, a} + {1'b0, b};
    a_nxt          = b;
    ovf_a_nxt      = ovf_b;
    ovf_b_nxt      = ovf_a | ovf_b | carry;
  end

endmodule

// File: rtl/fib_gen.sv
// rtl/fib_gen.sv - Fibonacci generator with single-result and streaming modes
module fib_gen
  import fib_pkg::*;
#(
  parameter int N_W    = FIB_N_W,
  parameter int DATA_W = FIB_DATA_W
) (
  input logic       CLK,
  input logic       rst,
  fib_gen_if.slave  bus
);

  fib_state_t        state, state_nxt;
  logic [DATA_W-1:0] a, b, a_step, b_step;
  logic              ovf_a, ovf_b, ovf_a_step, ovf_b_step;
  logic [N_W-1:0]    cnt, n_reg;
  logic              vld_r, vld_nxt;
  logic              accept, beat_done, is_last;
  logic              do_load, do_step;

  // a holds the presented term; in STREAM cnt is the index of the presented beat
  assign accept    = bus.vld_in && bus.rdy_in;
  assign beat_done = vld_r && bus.rdy_out;
  assign is_last   = (state == EMIT) || (cnt == n_reg);

  assign bus.rdy_in   = (state == IDLE) && !rst;
  assign bus.vld_out  = vld_r;
  assign bus.fib_out  = a;
  assign bus.ovf_out  = ovf_a;
  assign bus.last_out = vld_r && is_last;
  assign bus.busy     = (state != IDLE);

  fib_step #(.DATA_W(DATA_W)) u_step (
    .a         (a),
    .b         (b),
    .ovf_a     (ovf_a),
    .ovf_b     (ovf_b),
    .a_nxt     (a_step),
    .b_nxt     (b_step),
    .ovf_a_nxt (ovf_a_step),
    .ovf_b_nxt (ovf_b_step)
  );

  // state and output-valid registers
  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
      vld_r <= 1'b0;
    end else begin
      state <= state_nxt;
      vld_r <= vld_nxt;
    end
  end

  // next state, output valid and datapath load/step control
  always_comb begin
    state_nxt = state;
    vld_nxt   = vld_r;
    do_load   = 1'b0;
    do_step   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          do_load   = 1'b1;
          state_nxt = (bus.mode_in == MODE_STREAM) ? STREAM : CALC;
        end
      end
      CALC: begin
        if (cnt != n_reg) begin
          do_step = 1'b1;
        end else begin
          state_nxt = EMIT;
          vld_nxt   = 1'b1;
        end
      end
      EMIT: begin
        if (beat_done) begin
          state_nxt = IDLE;
          vld_nxt   = 1'b0;
        end
      end
      STREAM: begin
        if (!vld_r) begin
          vld_nxt = 1'b1;
        end else if (beat_done) begin
          if (is_last) begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
          end else begin
            do_step = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  // Fibonacci pair, overflow flags, step counter and latched index
  always_ff @(posedge CLK) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
      cnt   <= '0;
      n_reg <= '0;
    end else if (do_load) begin
      a     <= '0;
      b     <= DATA_W'(1);
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
      cnt   <= '0;
      n_reg <= bus.fib_in;
    end else if (do_step) begin
      a     <= a_step;
      b     <= b_step;
      ovf_a <= ovf_a_step;
      ovf_b <= ovf_b_step;
      cnt   <= cnt + N_W'(1);
    end
  end

endmodule

// File: tb/tb_fib_gen.sv
// tb/tb_fib_gen.sv - randomized self-checking bench for fib_gen against a Fibonacci table
module tb_fib_gen;
  import fib_pkg::*;

  localparam int N_W    = 8;
  localparam int DATA_W = 32;
  localparam longint unsigned CAP = 64'h10_0000_0000;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [DATA_W-1:0] fib_mod [0:255];
  bit                fib_ovf [0:255];
  longint unsigned   fib_big [0:255];

  fib_gen_if #(.N_W(N_W), .DATA_W(DATA_W)) bus ();

  fib_gen #(.N_W(N_W), .DATA_W(DATA_W)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // exact values saturate at CAP, which is well above 2^32, so the overflow test stays exact
  task automatic build_table();
    fib_mod[0] = '0;
    fib_mod[1] = DATA_W'(1);
    fib_big[0] = 0;
    fib_big[1] = 1;
    for (int k = 2; k < 256; k++) begin
      fib_mod[k] = fib_mod[k-1] + fib_mod[k-2];
      fib_big[k] = fib_big[k-1] + fib_big[k-2];
      if (fib_big[k] > CAP) fib_big[k] = CAP;
    end
    for (int k = 0; k < 256; k++) fib_ovf[k] = (fib_big[k] > 64'hFFFF_FFFF);
  endtask

  // stall: 0 = consumer always ready, 1 = ready toggles 1/0, 2 = random ready
  task automatic run_req(input int n, input logic mode, input int stall, input bit hold_vld);
    int                idx, beats, first_vld, nb, k;
    bit                done, held, r;
    logic [DATA_W-1:0] h_fib;
    logic              h_ovf, h_last;
    nb = (mode == MODE_STREAM) ? n + 1 : 1;
    check("rdy_in before request", bus.rdy_in, 1);
    bus.fib_in  = N_W'(n);
    bus.mode_in = mode;
    bus.vld_in  = 1'b1;
    bus.rdy_out = 1'b0;
    @(negedge CLK);
    if (!hold_vld) bus.vld_in = 1'b0;
    check("busy after accept", bus.busy, 1);
    check("rdy_in while busy", bus.rdy_in, 0);
    idx = 0; beats = 0; first_vld = -1; done = 0; held = 0;
    h_fib = '0; h_ovf = 1'b0; h_last = 1'b0;
    while (!done && idx < 2000) begin
      if (bus.vld_out && first_vld < 0) first_vld = idx;
      if (held) begin
        check("stall vld_out", bus.vld_out, 1);
        check("stall fib_out", bus.fib_out, h_fib);
        check("stall ovf_out", bus.ovf_out, h_ovf);
        check("stall last_out", bus.last_out, h_last);
      end
      case (stall)
        0:       r = 1'b1;
        1:       r = (idx % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.rdy_out = r;
      if (bus.vld_out && r) begin
        k = (mode == MODE_STREAM) ? beats : n;
        check("beat fib_out", bus.fib_out, fib_mod[k]);
        check("beat ovf_out", bus.ovf_out, fib_ovf[k]);
        check("beat last_out", bus.last_out, (beats == nb - 1));
        beats++;
        if (beats == nb) begin
          done = 1;
          bus.vld_in = 1'b0;
        end
      end
      held   = bus.vld_out && !r;
      h_fib  = bus.fib_out;
      h_ovf  = bus.ovf_out;
      h_last = bus.last_out;
      if (hold_vld && !done) begin
        bus.fib_in  = N_W'($urandom);
        bus.mode_in = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
      idx++;
    end
    check("request completed", done, 1);
    check("first beat latency", longint'(first_vld), (mode == MODE_STREAM) ? 1 : n + 1);
    check("rdy_in after last", bus.rdy_in, 1);
    check("busy after last", bus.busy, 0);
    check("vld_out after last", bus.vld_out, 0);
    bus.rdy_out = 1'b0;
    @(negedge CLK);
    check("no re-accept", bus.busy, 0);
  endtask

  task automatic reset_mid(input logic mode);
    bus.fib_in  = N_W'(200);
    bus.mode_in = mode;
    bus.vld_in  = 1'b1;
    bus.rdy_out = 1'b0;
    @(negedge CLK);
    bus.vld_in = 1'b0;
    repeat (30) @(negedge CLK);
    if (mode == MODE_SINGLE) check("vld_out mid calc", bus.vld_out, 0);
    else                     check("stalled beat present", bus.vld_out, 1);
    rst = 1'b1;
    @(negedge CLK);
    check("rst rdy_in", bus.rdy_in, 0);
    check("rst busy", bus.busy, 0);
    check("rst vld_out", bus.vld_out, 0);
    check("rst fib_out", bus.fib_out, 0);
    check("rst last_out", bus.last_out, 0);
    rst = 1'b0;
    @(negedge CLK);
    check("post rst rdy_in", bus.rdy_in, 1);
    check("post rst busy", bus.busy, 0);
    bus.rdy_out = 1'b1;
    repeat (5) @(negedge CLK);
    check("discarded request silent", bus.vld_out, 0);
    bus.rdy_out = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    build_table();
    bus.fib_in  = '0;
    bus.mode_in = MODE_SINGLE;
    bus.vld_in  = 1'b0;
    bus.rdy_out = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset rdy_in", bus.rdy_in, 0);
    check("reset vld_out", bus.vld_out, 0);
    check("reset busy", bus.busy, 0);
    check("reset fib_out", bus.fib_out, 0);
    check("reset ovf_out", bus.ovf_out, 0);
    check("reset last_out", bus.last_out, 0);
    rst = 1'b0;
    @(negedge CLK);

    run_req(6,  MODE_SINGLE, 0, 0);
    run_req(0,  MODE_SINGLE, 0, 0);
    run_req(1,  MODE_SINGLE, 0, 0);
    run_req(47, MODE_SINGLE, 0, 0);
    run_req(48, MODE_SINGLE, 2, 0);
    run_req(5,  MODE_STREAM, 1, 0);
    run_req(0,  MODE_STREAM, 0, 0);
    run_req(60, MODE_STREAM, 2, 0);
    run_req(10, MODE_SINGLE, 2, 1);
    run_req(50, MODE_STREAM, 0, 1);
    reset_mid(MODE_SINGLE);
    run_req(10, MODE_SINGLE, 0, 0);
    reset_mid(MODE_STREAM);

    for (int i = 0; i < 20; i++) begin
      run_req(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fib_gen.md
FIB_GEN -- requirements
Module: fib_gen

Interface
REQ-001 Parameter N_W, default 8: width of requested Fibonacci index.
REQ-002 Parameter DATA_W, default 32: width of result datapath.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fib_in  input  N_W  requested index n.
REQ-006 mode_in  input  1  0 = single (emit F(n) only), 1 = stream (emit F(0)..F(n)).
REQ-007 vld_in  input  1  request valid.
REQ-008 rdy_in  output  1  block ready to accept request.
REQ-009 fib_out  output  DATA_W  result beat, F(k) modulo 2^DATA_W.
REQ-010 ovf_out  output  1  true F(k) of current beat not representable in DATA_W.
REQ-011 last_out  output  1  current beat is final beat of request.
REQ-012 vld_out  output  1  result beat valid.
REQ-013 rdy_out  input  1  consumer ready for result beat.
REQ-014 busy  output  1  request accepted and not yet fully delivered.

Function
REQ-015 Request accepted on an edge where vld_in && rdy_in; fib_in and mode_in latched then; later changes to them are ignored.
REQ-016 rdy_in high only in IDLE; vld_out never high in IDLE.
REQ-017 States: IDLE, CALC, EMIT, STREAM; IDLE->CALC on single-mode accept, IDLE->STREAM on stream-mode accept.
REQ-018 On accept: a=0, b=1, cnt=0, ovf_a=0, ovf_b=0.
REQ-019 CALC, each cycle with cnt<n: a<=b, b<=a+b (DATA_W wrap), cnt<=cnt+1, ovf_a<=ovf_b, ovf_b<=ovf_a|ovf_b|carry-out.
REQ-020 CALC->EMIT when cnt==n; single-mode vld_out rises at edge k+n+1 after accept edge k (n=0 -> k+1); fib_out=a, ovf_out=ovf_a, last_out=1.
REQ-021 STREAM: first beat F(0) valid at edge k+1; each handshake (vld_out && rdy_out) advances a/b/ovf per REQ-019 and presents the next beat on the following edge, giving one beat per cycle with rdy_out held high.
REQ-022 Stream mode emits exactly n+1 beats; last_out high only on beat F(n); n=0 emits one beat, 0, last_out=1.
REQ-023 While vld_out && !rdy_out: fib_out, ovf_out, last_out and vld_out held stable.
REQ-024 Handshake on a last_out beat returns to IDLE; rdy_in high the following cycle; no new accept on the same edge.
REQ-025 Overflow flag is sticky along a sequence: once ovf_out=1 in a stream, all later beats of that stream have ovf_out=1.
REQ-026 busy = (state != IDLE).

Reset
REQ-027 rst high on an edge forces IDLE regardless of state, including mid-CALC and with a beat stalled.
REQ-028 Reset values: vld_out=0, fib_out=0, ovf_out=0, last_out=0, busy=0, rdy_in=1 (after the first edge with rst low), cnt=0, a=0, b=0; a pending request is discarded and no beat is emitted for it.
REQ-029 rdy_in held 0 while rst is high.

Structure
REQ-030 Package fib_pkg holds the state enum (IDLE, CALC, EMIT, STREAM), the mode constants MODE_SINGLE/MODE_STREAM, and default N_W/DATA_W constants.
REQ-031 Sub-module fib_step: combinational a/b/ovf next-value step (add, carry, overflow propagation) parametrised by DATA_W, instanced once; FSM, counter and handshake logic stay in fib_gen.

Verification
REQ-032 Single n=6, rdy_out=1: vld_out rises 7 edges after accept; fib_out=8, ovf_out=0, last_out=1; rdy_in back high next cycle.
REQ-033 Single n=0 -> fib_out=0 one edge after accept; n=1 -> fib_out=1 two edges after accept.
REQ-034 DATA_W=32: n=47 -> 2971215073, ovf_out=0; n=48 -> 512559680, ovf_out=1.
REQ-035 Stream n=5, rdy_out toggled 1/0 each cycle -> beats 0,1,1,2,3,5 in order, each held stable while stalled, last_out only on 5, exactly 6 handshakes.
REQ-036 Single n=200 with rst pulsed for one cycle mid-CALC -> vld_out stays 0, busy=0 and rdy_in=1 after reset; a following request n=10 returns 55.
REQ-037 vld_in held high with changing fib_in while busy -> no extra accepts; only the first latched request is answered.
